// File: rtl/nand_output_sampler_if.sv
// Signal bundle between the NAND gate output sampler and its consumer.
// The master side drives the gate level and the count clear; the slave is the sampler.
interface nand_output_sampler_if #(
  parameter int COUNT_WIDTH = 8
);
  logic                   gateData;
  logic                   clearCount;
  logic                   filteredData;
  logic                   risePulse;
  logic                   fallPulse;
  logic [COUNT_WIDTH-1:0] transitionCount;
  logic                   countSaturated;

  modport master (
    output gateData, clearCount,
    input  filteredData, risePulse, fallPulse, transitionCount, countSaturated
  );

  modport slave (
    input  gateData, clearCount,
    output filteredData, risePulse, fallPulse, transitionCount, countSaturated
  );
endinterface

// File: rtl/nand_output_sampler.sv
// Synchronises an asynchronous NAND gate output, rejects glitches shorter than
// FILTER_DEPTH cycles, and reports filtered edges as pulses plus a saturating count.
module nand_output_sampler #(
  parameter int   FILTER_DEPTH = 3,
  parameter int   COUNT_WIDTH  = 8,
  parameter logic RESET_LEVEL  = 1'b0
) (
  input logic                  clock,
  input logic                  reset,
  nand_output_sampler_if.slave bus
);
  localparam int STAB_W = $clog2(FILTER_DEPTH + 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

  typedef enum logic {ST_STABLE, ST_PENDING} state_t;

  logic                   r_sync1;
  logic                   r_sync2;
  state_t                 r_state;
  logic [STAB_W-1:0]      r_stab;
  logic                   r_filt;
  logic                   r_rise;
  logic                   r_fall;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_sat;

  logic w_mismatch;
  logic w_accept;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  // Two-flop synchroniser, nothing between the stages.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= RESET_LEVEL;
      r_sync2 <= RESET_LEVEL;
    end else begin
      r_sync1 <= bus.gateData;
      r_sync2 <= r_sync1;
    end
  end

  // Accept on the edge where the mismatch has been seen FILTER_DEPTH times in a row.
  assign w_mismatch = (r_sync2 != r_filt);
  assign w_accept   = w_mismatch && (r_stab == STAB_W'(FILTER_DEPTH - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_STABLE;
      r_stab  <= '0;
      r_filt  <= RESET_LEVEL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_count <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_rise <= w_accept &  r_sync2;
      r_fall <= w_accept & ~r_sync2;

      case (r_state)
        ST_STABLE: begin
          if (w_accept) begin
            r_filt <= r_sync2;
          end else if (w_mismatch) begin
            r_state <= ST_PENDING;
            r_stab  <= STAB_W'(1);
          end
        end
        ST_PENDING: begin
          if (!w_mismatch) begin
            r_state <= ST_STABLE;
            r_stab  <= '0;
          end else if (w_accept) begin
            r_filt  <= r_sync2;
            r_state <= ST_STABLE;
            r_stab  <= '0;
          end else begin
            r_stab <= r_stab + STAB_W'(1);
          end
        end
        default: begin
          r_state <= ST_STABLE;
          r_stab  <= '0;
        end
      endcase

      // A clear on the same edge as a transition wins over the increment.
      if (bus.clearCount) begin
        r_count <= '0;
        r_sat   <= 1'b0;
      end else if (w_accept) begin
        r_count <= sat_inc(r_count);
        if (r_count >= CNT_MAX - 1'b1) r_sat <= 1'b1;
      end
    end
  end

  assign bus.filteredData    = r_filt;
  assign bus.risePulse       = r_rise;
  assign bus.fallPulse       = r_fall;
  assign bus.transitionCount = r_count;
  assign bus.countSaturated  = r_sat;
endmodule

// File: tb/tb_nand_output_sampler.sv
// Randomised bench for nand_output_sampler: two instances (depth 3 / width 4 and
// depth 1 / width 8) checked every cycle against a sample-history reference model.
module tb_nand_output_sampler;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic gate  = 1'b0;
  logic clr   = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  nand_output_sampler_if #(.COUNT_WIDTH(4)) busA ();
  nand_output_sampler_if #(.COUNT_WIDTH(8)) busB ();

  assign busA.gateData   = gate;
  assign busA.clearCount = clr;
  assign busB.gateData   = gate;
  assign busB.clearCount = clr;

  nand_output_sampler #(.FILTER_DEPTH(3), .COUNT_WIDTH(4), .RESET_LEVEL(1'b0)) dutA (
    .clock(clock), .reset(reset), .bus(busA)
  );
  nand_output_sampler #(.FILTER_DEPTH(1), .COUNT_WIDTH(8), .RESET_LEVEL(1'b0)) dutB (
    .clock(clock), .reset(reset), .bus(busB)
  );

  always #5 clock = ~clock;

  // Reference: last few gate samples (hist[0] newest) plus per-instance outputs.
  int depth [2] = '{3, 1};
  int cmax  [2] = '{15, 255};
  int hist  [8];
  int m_filt[2];
  int m_rise[2];
  int m_fall[2];
  int m_cnt [2];
  int m_sat [2];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) hist[i] = 0;
    for (int d = 0; d < 2; d++) begin
      m_filt[d] = 0; m_rise[d] = 0; m_fall[d] = 0; m_cnt[d] = 0; m_sat[d] = 0;
    end
  endtask

  // The synchronised sample seen at an edge is the gate value two edges back;
  // a change is accepted once the last `depth` such samples all differ from the output.
  function automatic int will_accept(input int d);
    int acc = 1;
    for (int i = 1; i <= depth[d]; i++)
      if (hist[i] == m_filt[d]) acc = 0;
    return acc;
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int acc = will_accept(d);
      m_rise[d] = (acc == 1 && m_filt[d] == 0) ? 1 : 0;
      m_fall[d] = (acc == 1 && m_filt[d] == 1) ? 1 : 0;
      if (acc == 1) m_filt[d] = 1 - m_filt[d];
      if (clr) begin
        m_cnt[d] = 0;
        m_sat[d] = 0;
      end else if (acc == 1 && m_cnt[d] < cmax[d]) begin
        m_cnt[d]++;
        if (m_cnt[d] == cmax[d]) m_sat[d] = 1;
      end
    end
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = int'(gate);
  endtask

  task automatic check_all();
    chk("A.filt", int'(busA.filteredData),    m_filt[0]);
    chk("A.rise", int'(busA.risePulse),       m_rise[0]);
    chk("A.fall", int'(busA.fallPulse),       m_fall[0]);
    chk("A.cnt",  int'(busA.transitionCount), m_cnt[0]);
    chk("A.sat",  int'(busA.countSaturated),  m_sat[0]);
    chk("A.excl", int'(busA.risePulse & busA.fallPulse), 0);
    chk("B.filt", int'(busB.filteredData),    m_filt[1]);
    chk("B.rise", int'(busB.risePulse),       m_rise[1]);
    chk("B.fall", int'(busB.fallPulse),       m_fall[1]);
    chk("B.cnt",  int'(busB.transitionCount), m_cnt[1]);
    chk("B.sat",  int'(busB.countSaturated),  m_sat[1]);
  endtask

  // Called at a falling edge: drive, let one rising edge happen, check at the next fall.
  task automatic cyc(input logic g, input logic c);
    gate = g;
    clr  = c;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clock);
    check_all();
    reset = 1'b0;
  endtask

  // Edges (including the first) until instance A pulses rise, with gate held high.
  task automatic rise_latency(input string tag);
    int n = 0;
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc(1'b1, 1'b0);
      n++;
      if (busA.risePulse) seen = 1;
    end
    chk(tag, n, depth[0] + 2);
  endtask

  initial begin
    int run;
    logic g;
    bit hit;

    model_reset();
    @(negedge clock);
    check_all();
    reset = 1'b0;

    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0);
    rise_latency("A.rise_latency");
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0);

    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0);
    chk("A.glitch_filt", int'(busA.filteredData), 0);

    cyc(1'b0, 1'b1);
    g = 1'b0;
    for (int t = 0; t < 16; t++) begin
      g = ~g;
      for (int i = 0; i < 6; i++) cyc(g, 1'b0);
    end
    chk("A.sat_final", int'(busA.countSaturated), 1);
    chk("A.cnt_final", int'(busA.transitionCount), 15);

    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0);
    hit = 0;
    gate = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic c;
      c = (will_accept(0) == 1 && m_filt[0] == 1) ? 1'b1 : 1'b0;
      cyc(1'b0, c);
      if (c) begin
        hit = 1;
        chk("A.clr_fall_pulse", int'(busA.fallPulse), 1);
        chk("A.clr_fall_cnt",   int'(busA.transitionCount), 0);
      end
    end
    chk("A.clr_fall_seen", int'(hit), 1);

    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
    do_reset();
    rise_latency("A.rise_after_reset");
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
    chk("A.cnt_after_reset", int'(busA.transitionCount), 1);

    run = 0;
    g = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        g = ~g;
        run = $urandom_range(1, 8);
      end
      run--;
      if ($urandom_range(0, 399) == 0) do_reset();
      else cyc(g, ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
